// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single memory bus to the I-cache or D-cache and routes returning tags to their owner
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    proc2Imem_command,
  input  logic [XLEN-1:0]               proc2Imem_addr,
  input  logic [1:0]                    proc2Dmem_command,
  input  logic [XLEN-1:0]               proc2Dmem_addr,
  input  logic [63:0]                   proc2Dmem_data,
  input  logic [$clog2(NUM_TAGS)-1:0]   mem2proc_response,
  input  logic [63:0]                   mem2proc_data,
  input  logic [$clog2(NUM_TAGS)-1:0]   mem2proc_tag,
  output logic [1:0]                    proc2mem_command,
  output logic [XLEN-1:0]               proc2mem_addr,
  output logic [63:0]                   proc2mem_data,
  output logic                          d_request,
  output logic [$clog2(NUM_TAGS)-1:0]   Imem2proc_response,
  output logic [$clog2(NUM_TAGS)-1:0]   Imem2proc_tag,
  output logic [63:0]                   Imem2proc_data,
  output logic [$clog2(NUM_TAGS)-1:0]   Dmem2proc_response,
  output logic [$clog2(NUM_TAGS)-1:0]   Dmem2proc_tag,
  output logic [63:0]                   Dmem2proc_data,
  output logic [$clog2(NUM_TAGS):0]     i_outstanding,
  output logic [$clog2(NUM_TAGS):0]     d_outstanding
);
  localparam int CW = $clog2(NUM_TAGS) + 1;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  logic [2:0]          starve_cnt, starve_nx;
  logic [NUM_TAGS-1:0] valid, owner, valid_nx, owner_nx;
  logic [CW-1:0]       i_cnt_nx, d_cnt_nx;
  logic                i_idle, i_win, d_grant, i_grant, tag_live, alloc;
  assign i_idle   = proc2Imem_command == BUS_NONE;
  // a starved I-side load overrides the default D-side priority
  assign i_win    = starve_cnt >= 3'(STARVE_LIMIT) && proc2Imem_command == BUS_LOAD;
  assign d_grant  = !i_win && proc2Dmem_command != BUS_NONE;
  assign i_grant  = !d_grant && !i_idle;
  assign d_request = d_grant;
  assign proc2mem_command = d_grant ? proc2Dmem_command : i_grant ? proc2Imem_command : BUS_NONE;
  assign proc2mem_addr    = d_grant ? proc2Dmem_addr : i_grant ? proc2Imem_addr : '0;
  assign proc2mem_data    = d_grant ? proc2Dmem_data : '0;
  assign Imem2proc_response = mem2proc_response;
  assign Dmem2proc_response = d_grant ? mem2proc_response : '0;
  assign Imem2proc_data = mem2proc_data;
  assign Dmem2proc_data = mem2proc_data;
  // returning tags are routed by the table as it stood before this cycle's update
  assign tag_live      = mem2proc_tag != '0 && valid[mem2proc_tag];
  assign Imem2proc_tag = tag_live && !owner[mem2proc_tag] ? mem2proc_tag : '0;
  assign Dmem2proc_tag = tag_live && owner[mem2proc_tag] ? mem2proc_tag : '0;
  assign alloc = proc2mem_command == BUS_LOAD && mem2proc_response != '0;
  // aging: count I-side losses or rejections, clear on an accepted I grant, hold while idle
  assign starve_nx = i_idle ? starve_cnt :
                     (i_grant && mem2proc_response != '0) ? 3'd0 :
                     (starve_cnt == 3'd7) ? starve_cnt : starve_cnt + 3'd1;
  // next owner table: retire first so a same-tag allocate leaves the entry live with its new owner
  always_comb begin
    valid_nx = valid;
    owner_nx = owner;
    if (tag_live) valid_nx[mem2proc_tag] = 1'b0;
    if (alloc) begin
      valid_nx[mem2proc_response] = 1'b1;
      owner_nx[mem2proc_response] = d_grant;
    end
    i_cnt_nx = '0;
    d_cnt_nx = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      i_cnt_nx = i_cnt_nx + CW'(valid_nx[t] & ~owner_nx[t]);
      d_cnt_nx = d_cnt_nx + CW'(valid_nx[t] & owner_nx[t]);
    end
  end
  // table, aging counter and outstanding counts; reset drops every outstanding tag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid         <= '0;
      owner         <= '0;
      starve_cnt    <= '0;
      i_outstanding <= '0;
      d_outstanding <= '0;
    end else begin
      valid         <= valid_nx;
      owner         <= owner_nx;
      starve_cnt    <= starve_nx;
      i_outstanding <= i_cnt_nx;
      d_outstanding <= d_cnt_nx;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_mem_arbiter;
  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] S = 2'd2;
  logic        clock, reset;
  logic [1:0]  proc2Imem_command, proc2Dmem_command, proc2mem_command;
  logic [31:0] proc2Imem_addr, proc2Dmem_addr, proc2mem_addr;
  logic [63:0] proc2Dmem_data, mem2proc_data, proc2mem_data, Imem2proc_data, Dmem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [3:0]  Imem2proc_response, Imem2proc_tag, Dmem2proc_response, Dmem2proc_tag;
  logic        d_request;
  logic [4:0]  i_outstanding, d_outstanding;
  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic        dreq;
    logic [3:0]  iresp, itag, dresp, dtag;
    logic [63:0] idata, ddata;
    logic [4:0]  iout, dout;
  } exp_t;
  exp_t  exp_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    sidx     = 0;
  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_data(proc2Dmem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .d_request(d_request),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_tag(Imem2proc_tag),
    .Imem2proc_data(Imem2proc_data), .Dmem2proc_response(Dmem2proc_response),
    .Dmem2proc_tag(Dmem2proc_tag), .Dmem2proc_data(Dmem2proc_data),
    .i_outstanding(i_outstanding), .d_outstanding(d_outstanding)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, expv);
    end
  endtask
  // monitor: each cycle with a pending expectation, compare the sampled outputs mid-cycle
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, "cmd",   64'(proc2mem_command),   64'(e.cmd));
        chk(n, "addr",  64'(proc2mem_addr),      64'(e.addr));
        chk(n, "data",  proc2mem_data,           e.data);
        chk(n, "dreq",  64'(d_request),          64'(e.dreq));
        chk(n, "iresp", 64'(Imem2proc_response), 64'(e.iresp));
        chk(n, "itag",  64'(Imem2proc_tag),      64'(e.itag));
        chk(n, "idata", Imem2proc_data,          e.idata);
        chk(n, "dresp", 64'(Dmem2proc_response), 64'(e.dresp));
        chk(n, "dtag",  64'(Dmem2proc_tag),      64'(e.dtag));
        chk(n, "ddata", Dmem2proc_data,          e.ddata);
        chk(n, "iout",  64'(i_outstanding),      64'(e.iout));
        chk(n, "dout",  64'(d_outstanding),      64'(e.dout));
      end
    end
  end
  // drive one cycle of inputs and queue the hand-computed response for that cycle
  task automatic step(input string nm, input logic rp,
                      input logic [1:0] ic, input logic [31:0] ia,
                      input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                      input logic [3:0] rs, input logic [3:0] tg,
                      input logic [1:0] e_cmd, input logic [31:0] e_addr, input logic [63:0] e_data,
                      input logic e_dreq, input logic [3:0] e_itag, input logic [3:0] e_dtag,
                      input logic [4:0] e_iout, input logic [4:0] e_dout);
    exp_t e;
    @(posedge clock);
    #1;
    reset = 1'b1;
    sidx++;
    proc2Imem_command = ic;
    proc2Imem_addr    = ia;
    proc2Dmem_command = dc;
    proc2Dmem_addr    = da;
    proc2Dmem_data    = dd;
    mem2proc_response = rs;
    mem2proc_tag      = tg;
    mem2proc_data     = {32'hA5A5_0000, 32'(sidx)};
    if (rp) reset = 1'b0;
    e.cmd   = e_cmd;
    e.addr  = e_addr;
    e.data  = e_data;
    e.dreq  = e_dreq;
    e.iresp = rs;
    e.itag  = e_itag;
    e.dresp = e_dreq ? rs : 4'd0;
    e.dtag  = e_dtag;
    e.idata = {32'hA5A5_0000, 32'(sidx)};
    e.ddata = {32'hA5A5_0000, 32'(sidx)};
    e.iout  = e_iout;
    e.dout  = e_dout;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask
  initial begin
    reset = 1'b1;
    proc2Imem_command = N;
    proc2Imem_addr    = '0;
    proc2Dmem_command = N;
    proc2Dmem_addr    = '0;
    proc2Dmem_data    = '0;
    mem2proc_response = '0;
    mem2proc_tag      = '0;
    mem2proc_data     = '0;
    #3 reset = 1'b0;
    step("reset_state", 0, N, 0,      N, 0,      0,      0, 0, N, 0,      0,      0, 0, 0, 0, 0);
    step("i_load",      0, L, 'h100,  N, 0,      0,      3, 0, L, 'h100,  0,      0, 0, 0, 0, 0);
    step("i_ret3",      0, N, 0,      N, 0,      0,      0, 3, N, 0,      0,      0, 3, 0, 1, 0);
    step("i_drain",     0, N, 0,      N, 0,      0,      0, 0, N, 0,      0,      0, 0, 0, 0, 0);
    step("both_d",      0, L, 'h140,  L, 'h300,  'h1234, 5, 0, L, 'h300,  'h1234, 1, 0, 0, 0, 0);
    step("d_ret5",      0, N, 0,      N, 0,      0,      0, 5, N, 0,      0,      0, 0, 5, 0, 1);
    step("i_clr",       0, L, 'h180,  N, 0,      0,      1, 0, L, 'h180,  0,      0, 0, 0, 0, 0);
    step("starve1",     0, L, 'h1C0,  L, 'h400,  'h5555, 0, 1, L, 'h400,  'h5555, 1, 1, 0, 1, 0);
    step("starve2",     0, L, 'h1C0,  L, 'h400,  'h5555, 0, 0, L, 'h400,  'h5555, 1, 0, 0, 0, 0);
    step("starve3",     0, L, 'h1C0,  L, 'h400,  'h5555, 0, 0, L, 'h400,  'h5555, 1, 0, 0, 0, 0);
    step("starve4",     0, L, 'h1C0,  L, 'h400,  'h5555, 0, 0, L, 'h400,  'h5555, 1, 0, 0, 0, 0);
    step("starve_i",    0, L, 'h1C0,  L, 'h400,  'h5555, 6, 0, L, 'h1C0,  0,      0, 0, 0, 0, 0);
    step("starve_clr",  0, L, 'h1C0,  L, 'h400,  'h5555, 0, 6, L, 'h400,  'h5555, 1, 6, 0, 1, 0);
    step("d_store",     0, N, 0,      S, 'h200,  'hDEAD, 7, 0, S, 'h200,  'hDEAD, 1, 0, 0, 0, 0);
    step("st_ret7",     0, N, 0,      N, 0,      0,      0, 7, N, 0,      0,      0, 0, 0, 0, 0);
    step("i_alloc4",    0, L, 'h240,  N, 0,      0,      4, 0, L, 'h240,  0,      0, 0, 0, 0, 0);
    step("same_tag",    0, N, 0,      L, 'h500,  0,      4, 4, L, 'h500,  0,      1, 4, 0, 1, 0);
    step("owner_d",     0, N, 0,      N, 0,      0,      0, 0, N, 0,      0,      0, 0, 0, 0, 1);
    step("d_ret4",      0, N, 0,      N, 0,      0,      0, 4, N, 0,      0,      0, 0, 4, 0, 1);
    step("drain4",      0, N, 0,      N, 0,      0,      0, 0, N, 0,      0,      0, 0, 0, 0, 0);
    step("i_alloc2",    0, L, 'h280,  N, 0,      0,      2, 0, L, 'h280,  0,      0, 0, 0, 0, 0);
    step("d_alloc9",    0, N, 0,      L, 'h600,  0,      9, 0, L, 'h600,  0,      1, 0, 0, 1, 0);
    step("rst_mid",     1, N, 0,      N, 0,      0,      0, 0, N, 0,      0,      0, 0, 0, 0, 0);
    step("ret2_drop",   0, N, 0,      N, 0,      0,      0, 2, N, 0,      0,      0, 0, 0, 0, 0);
    step("ret9_drop",   0, N, 0,      N, 0,      0,      0, 9, N, 0,      0,      0, 0, 0, 0, 0);
    repeat (3) @(posedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
